// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_bank.sv
// Synchronous single-port RAM with byte write enables and a registered,
// clearable read-data port (array contents are never reset).
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic              clr,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     index,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<AW)-1];
    logic [DATA_W-1:0] rdata_r;

    // Byte-lane writes into the array
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem_r[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register: holds a loaded word until the consumer clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (en && !we) begin
            rdata_r <= mem_r[index];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder with programmable latency.
// Optional macro DMEM_MISALIGN_ERR_EN: flag and suppress misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    // With single-cycle latency the access happens on the accept edge itself
    localparam bit DIRECT = (LATENCY == 1);

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              req_ready_r, rsp_valid_r, rsp_err_r;
    logic              we_r, mis_r;
    logic [AW-1:0]     idx_r;
    logic [DATA_W-1:0] wdata_r;
    logic [BE_W-1:0]   be_r;

    logic              accept_s, enter_resp_s, handshake_s, mis_in_s;
    logic              acc_we_s, acc_mis_s, bank_en_s;
    logic [AW-1:0]     acc_idx_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic [BE_W-1:0]   acc_be_s;
    logic              unused_s;

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_in_s = (req_addr[1:0] != 2'b00);
`else
    assign mis_in_s = 1'b0;
`endif

    assign unused_s     = ^{req_addr[DATA_W-1:AW+2], req_addr[1:0]};
    assign accept_s     = req_valid && req_ready_r;
    assign handshake_s  = (state_r == RESP) && rsp_ready;
    assign enter_resp_s = (state_r != RESP) && (state_nxt_s == RESP);

    // Next-state and latency counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    cnt_nxt_s   = CNT_W'(LATENCY - 1);
                    state_nxt_s = DIRECT ? RESP : WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Select the access source: live request or the latched copy
    always_comb begin
        if (DIRECT) begin
            acc_we_s    = req_we;
            acc_idx_s   = req_addr[AW+1:2];
            acc_wdata_s = req_wdata;
            acc_be_s    = req_be;
            acc_mis_s   = mis_in_s;
        end else begin
            acc_we_s    = we_r;
            acc_idx_s   = idx_r;
            acc_wdata_s = wdata_r;
            acc_be_s    = be_r;
            acc_mis_s   = mis_r;
        end
    end

    assign bank_en_s = enter_resp_s && !acc_mis_s;

    // State, counter and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            if (enter_resp_s) begin
                rsp_err_r <= acc_mis_s;
            end else if (handshake_s) begin
                rsp_err_r <= 1'b0;
            end else begin
                rsp_err_r <= rsp_err_r;
            end
        end
    end

    // Request capture on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r    <= 1'b0;
            mis_r   <= 1'b0;
            idx_r   <= {AW{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            be_r    <= {BE_W{1'b0}};
        end else if (accept_s) begin
            we_r    <= req_we;
            mis_r   <= mis_in_s;
            idx_r   <= req_addr[AW+1:2];
            wdata_r <= req_wdata;
            be_r    <= req_be;
        end else begin
            we_r    <= we_r;
            mis_r   <= mis_r;
            idx_r   <= idx_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
        end
    end

    dmem_bank #(
        .AW(AW)
    ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (bank_en_s),
        .we   (acc_we_s),
        .clr  (handshake_s),
        .be   (acc_be_s),
        .index(acc_idx_s),
        .wdata(acc_wdata_s),
        .rdata(rsp_rdata)
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;

endmodule
